// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : 640x480@60 default timing and elaboration-time helper
//               functions for the VGA raster timing generator.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FRONT  = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BACK   = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FRONT  = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BACK   = 33;
    localparam int unsigned DEF_CNT_W    = 10;

    function automatic int unsigned axis_total(
        input int unsigned active,
        input int unsigned front,
        input int unsigned sync,
        input int unsigned back
    );
        return active + front + sync + back;
    endfunction

    // Every region must be non-empty and the counter must reach TOTAL-1.
    function automatic bit axis_params_ok(
        input int unsigned active,
        input int unsigned front,
        input int unsigned sync,
        input int unsigned back,
        input int unsigned cnt_w
    );
        longint unsigned span;
        span = longint'(1) << cnt_w;
        return (active != 0) && (front != 0) && (sync != 0) && (back != 0) &&
               (cnt_w != 0) && (cnt_w < 32) &&
               (span >= longint'(axis_total(active, front, sync, back)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_counter
// Description : One raster axis: wrapping position counter with registered
//               sync decode; exposes next-state count/active and wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL      = 800,
    parameter int unsigned SYNC_START = 656,
    parameter int unsigned SYNC_END   = 751,
    parameter int unsigned ACTIVE     = 640,
    parameter bit          POL        = 1'b0,
    parameter int unsigned CNT_W      = 10
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             step_i,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] count_next_o,
    output logic             sync_o,
    output logic             in_active_o,
    output logic             wrap_o
);

    localparam logic [CNT_W-1:0] C_LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] C_SYNC_START = CNT_W'(SYNC_START);
    localparam logic [CNT_W-1:0] C_SYNC_END   = CNT_W'(SYNC_END);
    localparam logic [CNT_W-1:0] C_ACTIVE     = CNT_W'(ACTIVE);

    logic [CNT_W-1:0] count_q, count_d;
    logic             sync_q, sync_d;
    logic             wrap_d;

    // Outputs are decoded from the next count so they line up with it.
    always_comb begin
        wrap_d  = step_i && (count_q == C_LAST);
        count_d = count_q;
        if (step_i) begin
            count_d = wrap_d ? '0 : count_q + 1'b1;
        end
        sync_d = ((count_d >= C_SYNC_START) && (count_d <= C_SYNC_END)) ? POL : ~POL;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= C_LAST;
            sync_q  <= ~POL;
        end else begin
            count_q <= count_d;
            sync_q  <= sync_d;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;
    assign sync_o       = sync_q;
    assign in_active_o  = (count_d < C_ACTIVE);
    assign wrap_o       = wrap_d;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA raster timing generator with registered,
//               mutually aligned sync, active, coordinate and strobe outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic             clock_25_mhz,
    input  logic             reset_n,
    input  logic             enable,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             line_start,
    output logic             frame_start
);

    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

    if (!axis_params_ok(H_ACTIVE, H_FRONT, H_SYNC, H_BACK, CNT_W)) begin : g_h_param_err
        $error("vga_timing_gen: bad horizontal timing or CNT_W too narrow");
    end
    if (!axis_params_ok(V_ACTIVE, V_FRONT, V_SYNC, V_BACK, CNT_W)) begin : g_v_param_err
        $error("vga_timing_gen: bad vertical timing or CNT_W too narrow");
    end

    logic [CNT_W-1:0] h_next, v_next;
    logic             h_act, v_act, h_wrap, v_wrap;

    logic             active_q, active_d;
    logic [CNT_W-1:0] pixel_x_q, pixel_x_d;
    logic [CNT_W-1:0] pixel_y_q, pixel_y_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .SYNC_START (H_ACTIVE + H_FRONT),
        .SYNC_END   (H_ACTIVE + H_FRONT + H_SYNC - 1),
        .ACTIVE     (H_ACTIVE),
        .POL        (HSYNC_POL),
        .CNT_W      (CNT_W)
    ) u_h_axis (
        .clk_i        (clock_25_mhz),
        .rst_n_i      (reset_n),
        .step_i       (enable),
        .count_o      (hcount),
        .count_next_o (h_next),
        .sync_o       (hsync),
        .in_active_o  (h_act),
        .wrap_o       (h_wrap)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .SYNC_START (V_ACTIVE + V_FRONT),
        .SYNC_END   (V_ACTIVE + V_FRONT + V_SYNC - 1),
        .ACTIVE     (V_ACTIVE),
        .POL        (VSYNC_POL),
        .CNT_W      (CNT_W)
    ) u_v_axis (
        .clk_i        (clock_25_mhz),
        .rst_n_i      (reset_n),
        .step_i       (h_wrap),
        .count_o      (vcount),
        .count_next_o (v_next),
        .sync_o       (vsync),
        .in_active_o  (v_act),
        .wrap_o       (v_wrap)
    );

    // h_wrap already carries enable, so strobes are zero while stalled.
    always_comb begin
        active_d      = h_act && v_act;
        pixel_x_d     = active_d ? h_next : '0;
        pixel_y_d     = active_d ? v_next : '0;
        line_start_d  = h_wrap;
        frame_start_d = h_wrap && v_wrap;
    end

    always_ff @(posedge clock_25_mhz or negedge reset_n) begin
        if (!reset_n) begin
            active_q      <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            active_q      <= active_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign active      = active_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Directed self-checking bench: default 640x480 instance plus
//               a small reparametrised instance covering full frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic       clk;
    logic       rst_n, en;
    logic       rst_s, en_s;

    logic [9:0] hcount, vcount, pixel_x, pixel_y;
    logic       hsync, vsync, active, line_start, frame_start;

    logic [9:0] s_hcount, s_vcount, s_pixel_x, s_pixel_y;
    logic       s_hsync, s_vsync, s_active, s_line_start, s_frame_start;

    int checks = 0;
    int errors = 0;

    vga_timing_gen dut (
        .clock_25_mhz (clk),
        .reset_n      (rst_n),
        .enable       (en),
        .hcount       (hcount),
        .vcount       (vcount),
        .hsync        (hsync),
        .vsync        (vsync),
        .active       (active),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .line_start   (line_start),
        .frame_start  (frame_start)
    );

    vga_timing_gen #(
        .H_ACTIVE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (1),
        .V_ACTIVE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
        .HSYNC_POL (1'b1), .VSYNC_POL (1'b0), .CNT_W (10)
    ) dut_s (
        .clock_25_mhz (clk),
        .reset_n      (rst_s),
        .enable       (en_s),
        .hcount       (s_hcount),
        .vcount       (s_vcount),
        .hsync        (s_hsync),
        .vsync        (s_vsync),
        .active       (s_active),
        .pixel_x      (s_pixel_x),
        .pixel_y      (s_pixel_y),
        .line_start   (s_line_start),
        .frame_start  (s_frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int hs_low;
        int ls_seen;
        int sm_h, sm_v, cyc, last_fs, last_ls, fs_cnt, vs_low;
        logic exp_hs, exp_vs, exp_act;

        rst_n = 1'b0; en = 1'b0;
        rst_s = 1'b0; en_s = 1'b0;
        step(3);

        // Reset state
        chk("rst_hcount", hcount, 799);
        chk("rst_vcount", vcount, 524);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_active", active, 0);
        chk("rst_pixel_x", pixel_x, 0);
        chk("rst_pixel_y", pixel_y, 0);
        chk("rst_line_start", line_start, 0);
        chk("rst_frame_start", frame_start, 0);

        rst_n = 1'b1;
        step(1);
        chk("idle_hcount", hcount, 799);
        chk("idle_ls", line_start, 0);

        // First enabled cycle lands on (0,0)
        en = 1'b1;
        step(1);
        chk("first_hcount", hcount, 0);
        chk("first_vcount", vcount, 0);
        chk("first_fs", frame_start, 1);
        chk("first_ls", line_start, 1);
        chk("first_active", active, 1);
        chk("first_hsync", hsync, 1);
        chk("first_vsync", vsync, 1);

        // Rest of line 0
        hs_low = 0; ls_seen = 0;
        for (int i = 1; i < 800; i++) begin
            step(1);
            chk("line_hcount", hcount, i);
            chk("line_hsync", hsync, (i >= 656 && i <= 751) ? 0 : 1);
            chk("line_active", active, (i < 640) ? 1 : 0);
            chk("line_pixel_x", pixel_x, (i < 640) ? i : 0);
            if (hsync == 1'b0) hs_low++;
            if (line_start) ls_seen++;
        end
        chk("hsync_low_width", hs_low, 96);
        chk("no_ls_midline", ls_seen, 0);
        chk("line_vsync", vsync, 1);

        // Stall at hcount=799
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(1);
            chk("stall_hcount", hcount, 799);
            chk("stall_vcount", vcount, 0);
            chk("stall_hsync", hsync, 1);
            chk("stall_active", active, 0);
            chk("stall_ls", line_start, 0);
            chk("stall_fs", frame_start, 0);
        end
        en = 1'b1;
        step(1);
        chk("wrap_hcount", hcount, 0);
        chk("wrap_vcount", vcount, 1);
        chk("wrap_ls", line_start, 1);
        chk("wrap_fs", frame_start, 0);
        chk("wrap_pixel_y", pixel_y, 1);
        step(1);
        chk("wrap_ls_single", line_start, 0);

        // Mid-line asynchronous reset
        step(299);
        chk("mid_hcount", hcount, 300);
        chk("mid_vcount", vcount, 1);
        chk("mid_pixel_x", pixel_x, 300);
        #2 rst_n = 1'b0;
        #1;
        chk("async_hcount", hcount, 799);
        chk("async_vcount", vcount, 524);
        chk("async_active", active, 0);
        chk("async_pixel_x", pixel_x, 0);
        chk("async_pixel_y", pixel_y, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        step(1);
        chk("rerun_hcount", hcount, 0);
        chk("rerun_vcount", vcount, 0);
        chk("rerun_fs", frame_start, 1);
        en = 1'b0;

        // Small instance: H 8/2/3/1 (14), V 4/1/1/1 (7), frame 98
        rst_s = 1'b1;
        step(1);
        chk("s_rst_hcount", s_hcount, 13);
        chk("s_rst_vcount", s_vcount, 6);
        chk("s_rst_hsync", s_hsync, 0);
        en_s = 1'b1;
        sm_h = 13; sm_v = 6;
        last_fs = -1; last_ls = -1; fs_cnt = 0; vs_low = 0;
        for (cyc = 0; cyc < 2 * 98 + 1; cyc++) begin
            step(1);
            if (sm_h == 13) begin
                sm_h = 0;
                sm_v = (sm_v == 6) ? 0 : sm_v + 1;
            end else begin
                sm_h = sm_h + 1;
            end
            exp_hs  = (sm_h >= 10 && sm_h <= 12);
            exp_vs  = (sm_v != 5);
            exp_act = (sm_h < 8) && (sm_v < 4);
            chk("s_hcount", s_hcount, sm_h);
            chk("s_vcount", s_vcount, sm_v);
            chk("s_hsync", s_hsync, exp_hs);
            chk("s_vsync", s_vsync, exp_vs);
            chk("s_active", s_active, exp_act);
            chk("s_pixel_x", s_pixel_x, exp_act ? sm_h : 0);
            chk("s_pixel_y", s_pixel_y, exp_act ? sm_v : 0);
            chk("s_ls", s_line_start, (sm_h == 0));
            chk("s_fs", s_frame_start, (sm_h == 0 && sm_v == 0));
            if (!s_vsync && cyc < 98) vs_low++;
            if (s_line_start) begin
                if (last_ls >= 0) chk("s_line_period", cyc - last_ls, 14);
                last_ls = cyc;
            end
            if (s_frame_start) begin
                if (last_fs >= 0) chk("s_frame_period", cyc - last_fs, 98);
                last_fs = cyc;
                fs_cnt++;
            end
        end
        chk("s_frame_count", fs_cnt, 3);
        chk("s_vsync_low_width", vs_low, 14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator: a horizontal counter and a vertical counter that step on every enabled pixel clock, driving sync pulses of configurable polarity, an active-video flag, pixel coordinates and line/frame strobes. It sits between the pixel-clock source and the clock-face pixel renderer, and supersedes the fixed 800-count horizontal counter. The vertical axis advances once per line wrap; no derived clocks are generated.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync
- VSYNC_POL, 0, asserted level of vsync
- CNT_W, 10, counter width; must satisfy 2^CNT_W >= max(H_TOTAL, V_TOTAL)

Ports:
- clock_25_mhz  input  1  pixel clock; all logic on its rising edge
- reset_n  input  1  asynchronous, active-low reset
- enable  input  1  advance raster by one pixel this cycle
- hcount  output  CNT_W  horizontal position, 0..H_TOTAL-1
- vcount  output  CNT_W  vertical position, 0..V_TOTAL-1
- hsync  output  1  horizontal sync, level HSYNC_POL when asserted
- vsync  output  1  vertical sync, level VSYNC_POL when asserted
- active  output  1  hcount < H_ACTIVE and vcount < V_ACTIVE
- pixel_x  output  CNT_W  hcount when active, else 0
- pixel_y  output  CNT_W  vcount when active, else 0
- line_start  output  1  one-cycle strobe on arrival at hcount = 0
- frame_start  output  1  one-cycle strobe on arrival at (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (default 800); V_TOTAL likewise (default 525).
- Horizontal regions: active [0, H_ACTIVE-1], front porch, sync [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1] (default 656..751), back porch. Vertical identical in lines (default sync 490..491).
- enable=1: hcount increments; at H_TOTAL-1 wraps to 0 and vcount increments; vcount at V_TOTAL-1 with hcount wrap goes to 0.
- enable=0: all counters and level outputs hold; line_start/frame_start forced 0.
- All outputs registered and mutually aligned: decode uses next-state counter values, so hsync/vsync/active/pixel_x/pixel_y/strobes describe exactly the hcount/vcount presented the same cycle.
- line_start = 1 only on the cycle hcount becomes 0 via an enabled step; frame_start additionally requires vcount becoming 0. frame_start implies line_start.
- hsync depends on hcount only; vsync depends on vcount only (vsync edges coincide with line_start).
- Reset (async assert, any time, mid-line or mid-frame): hcount = H_TOTAL-1, vcount = V_TOTAL-1, hsync = ~HSYNC_POL, vsync = ~VSYNC_POL, active = 0, pixel_x = pixel_y = 0, line_start = frame_start = 0. First enabled cycle after release lands on (0,0) with frame_start = line_start = 1, active = 1.
- Reset release is synchronised by the consumer; the block only requires reset_n deassertion meet recovery to clock_25_mhz.

## Timing
- Latency enable -> counter/output change: 1 clock edge.
- Line period: H_TOTAL enabled cycles; frame period: H_TOTAL*V_TOTAL enabled cycles (420 000 default).
- hsync low-pulse width: exactly H_SYNC enabled cycles; vsync: exactly V_SYNC*H_TOTAL enabled cycles.
- No combinational path from any input to any output.

## Structure
- Package vga_timing_pkg: default 640x480@60 timing constants, H_TOTAL/V_TOTAL derivation function, elaboration-time width check helper.
- One sub-module, vga_axis_counter (parameters TOTAL, SYNC_START, SYNC_END, ACTIVE, POL, CNT_W; inputs step; outputs count, sync, in_active, wrap), instantiated twice: horizontal stepped by enable, vertical stepped by horizontal wrap.
- Elaboration error if CNT_W too narrow or any region width is 0.

## Test plan
- Reset then enable=1 for 1 cycle -> hcount=0, vcount=0, frame_start=1, line_start=1, active=1, hsync=vsync=1 (defaults).
- Run one line -> hsync=0 exactly for hcount 656..751 (96 cycles); active drops at hcount=640; line_start recurs after 800 cycles with vcount=1.
- Run full frame -> vsync=0 for vcount 490..491 (1600 cycles); frame_start period 420 000 cycles; pixel_x/pixel_y = 0 whenever active=0.
- Toggle enable low for 7 cycles at hcount=799 -> all outputs hold, no strobe; next enabled cycle wraps to hcount=0 with single line_start.
- Assert reset_n low mid-frame (e.g. hcount=300, vcount=200) asynchronously -> outputs take reset values before next clock edge.
- Reparametrise (H_ACTIVE=8, H_FRONT=2, H_SYNC=3, H_BACK=1, V totals 4/1/1/1, HSYNC_POL=1) -> hsync=1 for hcount 10..12, line period 14, frame period 98.
